// File: rtl/mux_serializer_ctrl_if.sv
// mux_serializer_ctrl_if: byte handshake, mux drive/return and serial stream bundle
interface mux_serializer_ctrl_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] I;
  logic [2:0] Sel;
  logic       Y;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_last;
  logic       busy;
  modport master (output din, din_valid, Y, input din_ready, I, Sel, ser_out, ser_valid, ser_last, busy);
  modport slave  (input din, din_valid, Y, output din_ready, I, Sel, ser_out, ser_valid, ser_last, busy);
endinterface

// File: rtl/mux_serializer_ctrl.sv
// mux_serializer_ctrl: steps an 8-to-1 mux through a byte and samples it into a serial stream
module mux_serializer_ctrl #(
  parameter int HOLD_CYCLES = 1,
  parameter bit MSB_FIRST   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_serializer_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [2:0] FIRST  = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [3:0] HC_MAX = 4'(HOLD_CYCLES - 1);
  state_t     state, state_nx;
  logic [2:0] bit_cnt;
  logic [3:0] hold_cnt;
  logic       sample, last, accept;
  assign sample        = state == SHIFT && hold_cnt == HC_MAX;
  assign last          = sample && bit_cnt == 3'd7;
  assign bus.din_ready = state == IDLE || last;
  assign accept        = bus.din_valid && bus.din_ready;
  assign bus.busy      = state == SHIFT;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? SHIFT : IDLE;
    else if (last) state_nx = accept ? SHIFT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.I         <= 8'h00;
      bus.Sel       <= FIRST;
      bit_cnt       <= 3'd0;
      hold_cnt      <= 4'd0;
      bus.ser_out   <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.ser_last  <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.ser_valid <= sample;
      bus.ser_last  <= last;
      if (sample) bus.ser_out <= bus.Y;
      if (accept) bus.I <= bus.din;
      if (state == IDLE) begin
        if (accept) begin
          bus.Sel  <= FIRST;
          bit_cnt  <= 3'd0;
          hold_cnt <= 4'd0;
        end
      end else if (sample) begin
        // Wrapping step returns Sel to FIRST and bit_cnt to 0 after the 8th bit
        hold_cnt <= 4'd0;
        bit_cnt  <= bit_cnt + 3'd1;
        bus.Sel  <= MSB_FIRST ? bus.Sel - 3'd1 : bus.Sel + 3'd1;
      end else begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// tb_mux_serializer_ctrl: directed checks on an LSB-first/HOLD=1 and an MSB-first/HOLD=3 instance
module tb_mux_serializer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  mux_serializer_ctrl_if ifa ();
  mux_serializer_ctrl_if ifb ();
  assign ifa.Y = ifa.I[ifa.Sel];
  assign ifb.Y = ifb.I[ifb.Sel];
  mux_serializer_ctrl #(.HOLD_CYCLES(1), .MSB_FIRST(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mux_serializer_ctrl #(.HOLD_CYCLES(3), .MSB_FIRST(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.din = 8'hEE;
    ifa.din_valid = 1'b1;
    ifb.din = 8'h00;
    ifb.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifa.I !== 8'h00) $display("FAIL rst_I got %h want 00", ifa.I); else passes++;
    checks++; if (ifa.Sel !== 3'd0) $display("FAIL rst_Sel got %0d want 0", ifa.Sel); else passes++;
    checks++; if (ifa.ser_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", ifa.ser_valid); else passes++;
    checks++; if (ifa.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", ifa.busy); else passes++;
    checks++; if (ifa.din_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", ifa.din_ready); else passes++;
    checks++; if (ifb.Sel !== 3'd7) $display("FAIL rst_Sel_msb got %0d want 7", ifb.Sel); else passes++;
    ifa.din_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ifa.busy !== 1'b0) $display("FAIL idle_busy got %b want 0", ifa.busy); else passes++;
  endtask

  task automatic test_single_lsb();
    logic [7:0] rx = 8'h00;
    int n = 0, first = -1, lastk = -1;
    logic [31:0] lmask = 0;
    @(negedge clk);
    ifa.din = 8'hA5;
    ifa.din_valid = 1'b1;
    @(negedge clk);
    ifa.din_valid = 1'b0;
    ifa.din = 8'h00;
    checks++; if (ifa.busy !== 1'b1) $display("FAIL single_busy got %b want 1", ifa.busy); else passes++;
    checks++; if (ifa.I !== 8'hA5) $display("FAIL single_I got %h want a5", ifa.I); else passes++;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifa.ser_valid) begin
        rx = {ifa.ser_out, rx[7:1]};
        if (ifa.ser_last) lmask |= 32'(1) << n;
        if (first < 0) first = k;
        lastk = k;
        n++;
      end
    end
    checks++; if (n != 8) $display("FAIL single_count got %0d want 8", n); else passes++;
    checks++; if (rx !== 8'hA5) $display("FAIL single_data got %h want a5", rx); else passes++;
    checks++; if (lmask !== 32'h80) $display("FAIL single_last got %h want 80", lmask); else passes++;
    checks++; if (first != 1 || lastk != 8) $display("FAIL single_timing got %0d..%0d want 1..8", first, lastk); else passes++;
    checks++; if (ifa.busy !== 1'b0 || ifa.Sel !== 3'd0) $display("FAIL single_end got busy=%b Sel=%0d want 0/0", ifa.busy, ifa.Sel); else passes++;
  endtask

  task automatic test_held_msb();
    logic [7:0] rx = 8'h00;
    logic [31:0] vmask = 0;
    int sel_err = 0, busy_n = 0, lastk = -1, exp_sel;
    @(negedge clk);
    ifb.din = 8'h81;
    ifb.din_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) ifb.din_valid = 1'b0;
      exp_sel = k < 24 ? 7 - k / 3 : 7;
      if (ifb.Sel !== 3'(exp_sel)) sel_err++;
      if (ifb.busy) busy_n++;
      if (ifb.ser_valid) begin
        vmask |= 32'(1) << k;
        rx = {rx[6:0], ifb.ser_out};
      end
      if (ifb.ser_last) lastk = k;
    end
    checks++; if (sel_err != 0) $display("FAIL held_sel got %0d errors want 0", sel_err); else passes++;
    checks++; if (busy_n != 24) $display("FAIL held_busy got %0d want 24", busy_n); else passes++;
    checks++; if (vmask !== 32'h0124_9248) $display("FAIL held_valid got %h want 01249248", vmask); else passes++;
    checks++; if (rx !== 8'h81) $display("FAIL held_data got %h want 81", rx); else passes++;
    checks++; if (lastk != 24) $display("FAIL held_last got %0d want 24", lastk); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx = 16'h0;
    logic [31:0] vmask = 0, lmask = 0, rmask = 0;
    @(negedge clk);
    ifa.din = 8'hFF;
    ifa.din_valid = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      if (ifa.din_ready) rmask |= 32'(1) << k;
      if (ifa.ser_valid) begin
        vmask |= 32'(1) << k;
        rx = {rx[14:0], ifa.ser_out};
      end
      if (ifa.ser_last) lmask |= 32'(1) << k;
      if (k == 0) ifa.din = 8'h00;
      if (k == 8) ifa.din_valid = 1'b0;
    end
    checks++; if (vmask !== 32'h0001_FFFE) $display("FAIL b2b_valid got %h want 0001fffe", vmask); else passes++;
    checks++; if (rx !== 16'hFF00) $display("FAIL b2b_data got %h want ff00", rx); else passes++;
    checks++; if (lmask !== 32'h0001_0100) $display("FAIL b2b_last got %h want 00010100", lmask); else passes++;
    checks++; if (rmask[15:0] !== 16'h8080) $display("FAIL b2b_ready got %h want 8080", rmask[15:0]); else passes++;
    checks++; if (ifa.busy !== 1'b0) $display("FAIL b2b_busy got %b want 0", ifa.busy); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx = 8'h00;
    int n = 0, extra = 0;
    @(negedge clk);
    ifa.din = 8'h3C;
    ifa.din_valid = 1'b1;
    @(negedge clk);
    ifa.din_valid = 1'b0;
    for (int k = 0; k < 10 && n < 3; k++) begin
      @(negedge clk);
      if (ifa.ser_valid) n++;
    end
    checks++; if (n != 3) $display("FAIL mid_pre got %0d bits want 3", n); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (ifa.ser_valid !== 1'b0 || ifa.ser_last !== 1'b0) $display("FAIL mid_valid got %b%b want 00", ifa.ser_valid, ifa.ser_last); else passes++;
    checks++; if (ifa.busy !== 1'b0 || ifa.din_ready !== 1'b1) $display("FAIL mid_state got busy=%b ready=%b want 0/1", ifa.busy, ifa.din_ready); else passes++;
    checks++; if (ifa.I !== 8'h00 || ifa.Sel !== 3'd0) $display("FAIL mid_regs got I=%h Sel=%0d want 00/0", ifa.I, ifa.Sel); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (ifa.ser_valid) extra++;
    end
    checks++; if (extra != 0) $display("FAIL mid_extra got %0d want 0", extra); else passes++;
    ifa.din = 8'h01;
    ifa.din_valid = 1'b1;
    @(negedge clk);
    ifa.din_valid = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifa.ser_valid) begin
        rx = {ifa.ser_out, rx[7:1]};
        n++;
      end
    end
    checks++; if (n != 8 || rx !== 8'h01) $display("FAIL mid_next got n=%0d data=%h want 8/01", n, rx); else passes++;
  endtask

  task automatic test_backpressure();
    logic [15:0] rx = 16'h0;
    logic [31:0] rmask = 0;
    int nv = 0, i_err = 0;
    logic [7:0] i_at8 = 8'h00;
    @(negedge clk);
    ifa.din = 8'hAA;
    ifa.din_valid = 1'b1;
    @(negedge clk);
    ifa.din_valid = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (ifa.din_ready) rmask |= 32'(1) << k;
      if (ifa.ser_valid) begin
        rx = {ifa.ser_out, rx[15:1]};
        nv++;
      end
      if (k >= 2 && k <= 7 && ifa.I !== 8'hAA) i_err++;
      if (k == 8) begin
        i_at8 = ifa.I;
        ifa.din_valid = 1'b0;
      end
      if (k == 2) begin
        ifa.din = 8'h55;
        ifa.din_valid = 1'b1;
      end
    end
    checks++; if (rmask[7:2] !== 6'b100000) $display("FAIL bp_ready got %b want 100000", rmask[7:2]); else passes++;
    checks++; if (i_err != 0) $display("FAIL bp_I_hold got %0d errors want 0", i_err); else passes++;
    checks++; if (i_at8 !== 8'h55) $display("FAIL bp_I_new got %h want 55", i_at8); else passes++;
    checks++; if (nv != 16 || rx !== 16'h55AA) $display("FAIL bp_data got n=%0d data=%h want 16/55aa", nv, rx); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_lsb();
    test_held_msb();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mux_serializer_ctrl.md
# mux_serializer_ctrl

Byte-to-bit-stream sequencer wrapped around the 8-to-1 bit multiplexer. It accepts a byte on a valid/ready handshake, drives the byte onto the multiplexer data inputs, steps the multiplexer select through all eight positions, and samples the multiplexer output back into a registered serial stream with per-bit valid and end-of-frame markers. Upstream, it sits directly behind the byte producer. Downstream, it feeds the serial line logic.

## Interface
- HOLD_CYCLES, 1: clock cycles each bit is held on the mux before it is sampled. Legal range is 1..16.
- MSB_FIRST, 0: 0 means bit order I[0]→I[7] (Sel 0→7). 1 means bit order I[7]→I[0] (Sel 7→0).
- clk  input  1  sole clock; all flops are rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  8  byte to serialize.
- din_valid  input  1  din is offered.
- din_ready  output  1  combinational; the byte is accepted on the rising edge where din_valid && din_ready.
- I  output  8  registered byte driven to the mux data inputs.
- Sel  output  3  registered mux select.
- Y  input  1  mux output; combinational return path from I/Sel.
- ser_out  output  1  registered sampled bit.
- ser_valid  output  1  one-cycle pulse per sampled bit.
- ser_last  output  1  asserted together with ser_valid on the 8th bit of a byte.
- busy  output  1  high while in the SHIFT state.

## Operation
- The FSM has two states: IDLE and SHIFT. It also uses bit_cnt (3 bits) and hold_cnt (4 bits).
- **Reset values:**
  - state = IDLE.
  - I = 8'h00.
  - Sel = first index (0, or 7 when MSB_FIRST=1).
  - bit_cnt = 0 and hold_cnt = 0.
  - ser_out, ser_valid, ser_last and busy are all 0.
- **din_ready rule:** din_ready = (state==IDLE) || (state==SHIFT && bit_cnt==7 && hold_cnt==HOLD_CYCLES-1). Because state is IDLE during reset, din_ready reads 1 while rst_n is low. din is ignored until rst_n is released.
- **IDLE:**
  - On accept, I <= din, Sel <= first index, bit_cnt <= 0, hold_cnt <= 0, and the FSM moves to SHIFT.
  - Without an accept, all registers hold their values. Sel sits at the first index.
- **SHIFT, when hold_cnt < HOLD_CYCLES-1:** hold_cnt increments and nothing else changes.
- **SHIFT, when hold_cnt == HOLD_CYCLES-1 (the sample edge):**
  - ser_out <= Y and ser_valid <= 1.
  - ser_last <= (bit_cnt==7).
  - hold_cnt <= 0 and bit_cnt increments.
  - Sel steps +1 (or -1 when MSB_FIRST=1), wrapping modulo 8. After the 8th bit, Sel is therefore back at the first index.
- **End of the 8th bit:**
  - If an accept coincides with this sample edge, I <= din, bit_cnt <= 0, and the FSM stays in SHIFT. This gives back-to-back bytes with no gap.
  - Otherwise the FSM goes to IDLE.
- **Outside sample edges:** ser_valid and ser_last are 0 on every edge that is not a sample edge.
- **I stability:** I changes only on an accept. It is stable for the whole frame.
- **Reset mid-frame:** the frame is aborted immediately. No further ser_valid is produced, and the partial byte is discarded.
- **din_valid while not ready:** ignored. The producer must hold din until it is accepted.

## Timing
- **Accept to first bit:** accept at edge T0, then I/Sel update at T0. The first ser_valid is high in the cycle after edge T0+HOLD_CYCLES.
- **Bit spacing:** bits arrive HOLD_CYCLES cycles apart.
- **Frame timing:**
  - A frame occupies 8*HOLD_CYCLES cycles of SHIFT.
  - ser_last coincides with the 8th ser_valid.
  - busy falls on the same edge that produces the 8th bit, unless a back-to-back accept occurs on that edge.
- **HOLD_CYCLES=1 throughput:** ser_valid stays continuously high for 8 cycles per byte. With a sustained din_valid, it stays high indefinitely.
- **Y path:** Y is sampled with one full cycle of settling after each Sel/I change. The mux path must meet single-cycle timing.

## Test plan
- **Reset values:** rst_n low → I=00, Sel=0, ser_valid=0, busy=0, din_ready=1.
- **Single byte, LSB-first:** HOLD=1, MSB_FIRST=0, din=8'hA5 accepted once → ser_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles. ser_last is on the 8th only. The FSM then returns to IDLE with Sel=0.
- **Held bits, MSB-first:** HOLD=3, MSB_FIRST=1, din=8'h81 → Sel sequence 7,6,…,0, each held 3 cycles. ser_out sequence 1,0,0,0,0,0,0,1. ser_valid pulses are spaced 3 cycles apart, for 24 SHIFT cycles total.
- **Back-to-back bytes:** HOLD=1, din_valid held high with 8'hFF then 8'h00 → 16 consecutive ser_valid cycles with no gap (eight 1s then eight 0s). ser_last fires on the 8th and 16th bits. din_ready pulses only on the final bit cycle.
- **Reset mid-frame:** rst_n asserted after the 3rd ser_valid of 8'h3C → all outputs take their reset values on the same cycle. No further ser_valid occurs. The next byte, 8'h01, serializes cleanly.
- **Backpressure:** din_valid asserted mid-frame with 8'h55 → no accept until the last bit. I is unchanged until then, and 8'h55 then serializes intact.
